// File: rtl/i2s_pkg.sv
// Shared I2S definitions: controller state, default sample width,
// word-select polarity and the frame-length helper.
package i2s_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2s_state_e;

  localparam int SAMPLE_W_DEF = 16;

  // Word select level that marks the left channel.
  localparam logic WS_LEFT = 1'b0;

  // Number of SCK periods in one stereo frame.
  function automatic int frame_len(input int sample_w);
    return 2 * sample_w;
  endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// I2S serial clock generator. While run is high, div_cnt counts 0..div and
// SCK toggles at each terminal count, giving a period of 2*(div+1) clocks.
// fall_strobe marks the clk edge on which SCK goes 1->0. Outside run the
// generator sits at div_cnt=0, sck=0 so a new run always starts with a
// full low half-period.
module i2s_sck_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             sck,
  output logic             fall_strobe
);

  logic [DIV_W-1:0] div_cnt;
  logic             term;

  assign term        = (div_cnt == div);
  assign fall_strobe = run & term & sck;

  // Half-period counter and SCK toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (term) begin
      div_cnt <= '0;
      sck     <= ~sck;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// Philips I2S master transmitter. Pops one stereo word per frame from the TX
// FIFO and shifts it out MSB-first, left channel first, with WS leading the
// data by one SCK. All serial outputs change only on falling SCK edges.
// Optional build macro I2S_TX_UNDERRUN_REPEAT_EN: on underrun, replay the
// last fetched word instead of zeros.
module i2s_tx_serializer
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int DIV_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_enable,
  input  logic [DIV_W-1:0]      clk_div,
  input  logic [2*SAMPLE_W-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ack,
  output logic                  i2s_sck,
  output logic                  i2s_ws,
  output logic                  i2s_sd,
  output logic                  underrun,
  output logic                  busy
);

  localparam int FRAME = frame_len(SAMPLE_W);
  localparam int BC_W  = $clog2(FRAME);
  localparam logic [BC_W-1:0] BC_R_LSB = BC_W'(FRAME - 1);
  localparam logic [BC_W-1:0] BC_L_LSB = BC_W'(SAMPLE_W - 1);

  i2s_state_e       state;
  logic [DIV_W-1:0] div_reg;
  logic [BC_W-1:0]  bit_cnt;
  logic [BC_W-1:0]  bit_nxt;
  logic [FRAME-1:0] shreg;
  logic [FRAME-1:0] fill_word;
  logic             pre_slot;
  logic             fall;

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  logic [FRAME-1:0] last_word;
  assign fill_word = last_word;
`else
  assign fill_word = '0;
`endif

  assign busy    = (state == RUN);
  assign bit_nxt = (bit_cnt == BC_R_LSB) ? '0 : bit_cnt + BC_W'(1);

  i2s_sck_gen #(
    .DIV_W (DIV_W)
  ) u_sck_gen (
    .clk         (clk),
    .rst         (rst),
    .run         (busy),
    .div         (div_reg),
    .sck         (i2s_sck),
    .fall_strobe (fall)
  );

  // Frame controller: start/stop, FIFO fetch and MSB-first shifting on SCK falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      div_reg     <= '0;
      bit_cnt     <= BC_R_LSB;
      shreg       <= '0;
      pre_slot    <= 1'b0;
      i2s_ws      <= ~WS_LEFT;
      i2s_sd      <= 1'b0;
      data_in_ack <= 1'b0;
      underrun    <= 1'b0;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
      last_word   <= '0;
`endif
    end else begin
      data_in_ack <= 1'b0;
      underrun    <= 1'b0;
      if (state == IDLE) begin
        if (tx_enable) begin
          div_reg  <= clk_div;
          pre_slot <= 1'b1;
          state    <= RUN;
        end
      end else if (fall) begin
        if (pre_slot) begin
          // First fall after enable stands in for the previous right LSB.
          pre_slot <= 1'b0;
          i2s_ws   <= WS_LEFT;
          i2s_sd   <= 1'b0;
        end else if (bit_nxt == '0) begin
          if (tx_enable) begin
            bit_cnt <= bit_nxt;
            if (data_in_valid) begin
              data_in_ack <= 1'b1;
              i2s_sd      <= data_in[FRAME-1];
              shreg       <= {data_in[FRAME-2:0], 1'b0};
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
              last_word   <= data_in;
`endif
            end else begin
              underrun <= 1'b1;
              i2s_sd   <= fill_word[FRAME-1];
              shreg    <= {fill_word[FRAME-2:0], 1'b0};
            end
          end else begin
            state   <= IDLE;
            bit_cnt <= BC_R_LSB;
            shreg   <= '0;
            i2s_ws  <= ~WS_LEFT;
            i2s_sd  <= 1'b0;
          end
        end else begin
          bit_cnt <= bit_nxt;
          i2s_sd  <= shreg[FRAME-1];
          shreg   <= {shreg[FRAME-2:0], 1'b0};
          if (bit_nxt == BC_R_LSB) begin
            i2s_ws <= WS_LEFT;
          end else if (bit_nxt == BC_L_LSB) begin
            i2s_ws <= ~WS_LEFT;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: a slot-level model of the I2S stream checked
// against the DUT on every clock, plus literal expectations per scenario.
module tb_i2s_tx_serializer;

  localparam int SW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          tx_enable;
  logic [DW-1:0] clk_div;
  logic [31:0]   data_in;
  logic          data_in_valid;
  logic          data_in_ack;
  logic          i2s_sck;
  logic          i2s_ws;
  logic          i2s_sd;
  logic          underrun;
  logic          busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] tw [8];
  logic        tv [8];

  int          ack_cnt;
  int          und_cnt;
  int          busy_cnt;
  int          ack_n [$];
  logic [31:0] sd_vec;
  logic [31:0] ws_vec;

  i2s_tx_serializer #(.SAMPLE_W(SW), .DIV_W(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .tx_enable     (tx_enable),
    .clk_div       (clk_div),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ack   (data_in_ack),
    .i2s_sck       (i2s_sck),
    .i2s_ws        (i2s_ws),
    .i2s_sd        (i2s_sd),
    .underrun      (underrun),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Word actually played in frame f (underrun -> zeros or replay of last good word).
  function automatic logic [31:0] frame_word(input int f);
    if (tv[f]) return tw[f];
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    for (int j = f - 1; j >= 0; j--) if (tv[j]) return tw[j];
`endif
    return 32'h0;
  endfunction

  // Expected {sck, ws, sd, ack, underrun, busy} n clocks after the enable edge.
  // Slot k = number of SCK falls so far; slot 1 is the pre-frame slot,
  // slot 2+32f+b carries bit b (MSB-first, left first) of frame f.
  function automatic logic [5:0] model(input int n, input int d, input int nf);
    int p, nend, k, s, f, b;
    logic [31:0] w;
    logic sck, ws, sd, ack, und;
    p    = 2 * (d + 1);
    nend = (2 + 32 * nf) * p;
    if (n < 0 || n >= nend) return 6'b010000;
    sck = ((n / (d + 1)) % 2) == 1;
    k   = n / p;
    ack = 1'b0;
    und = 1'b0;
    if (k == 0) begin
      ws = 1'b1; sd = 1'b0;
    end else if (k == 1) begin
      ws = 1'b0; sd = 1'b0;
    end else begin
      s  = k - 2;
      f  = s / 32;
      b  = s % 32;
      ws = (b >= 15 && b <= 30);
      w  = frame_word(f);
      sd = w[31 - b];
      if (n % p == 0 && b == 0) begin
        ack = tv[f];
        und = !tv[f];
      end
    end
    return {sck, ws, sd, ack, und, 1'b1};
  endfunction

  // Runs one enable episode of nf frames at divider d, comparing every cycle.
  // tx_enable drops at left bit drop_bit of the last frame; abort_n >= 0
  // fires an asynchronous reset at that cycle; new_div >= 0 is driven on
  // clk_div while busy.
  task automatic run_test(input int d, input int nf, input int drop_bit,
                          input int abort_n, input int new_div);
    int p, nend, k, fnext;
    logic [5:0] e;
    p        = 2 * (d + 1);
    nend     = (2 + 32 * nf) * p;
    ack_cnt  = 0;
    und_cnt  = 0;
    busy_cnt = 0;
    ack_n.delete();
    sd_vec   = '0;
    ws_vec   = '0;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_ws", {31'd0, i2s_ws}, 32'd1);
    clk_div       = DW'(d);
    tx_enable     = 1'b1;
    data_in       = tw[0];
    data_in_valid = tv[0];
    for (int n = 0; n < nend + 3 * p; n++) begin
      @(negedge clk);
      e = model(n, d, nf);
      chk("sck",      {31'd0, i2s_sck},     {31'd0, e[5]});
      chk("ws",       {31'd0, i2s_ws},      {31'd0, e[4]});
      chk("sd",       {31'd0, i2s_sd},      {31'd0, e[3]});
      chk("ack",      {31'd0, data_in_ack}, {31'd0, e[2]});
      chk("underrun", {31'd0, underrun},    {31'd0, e[1]});
      chk("busy",     {31'd0, busy},        {31'd0, e[0]});
      k = n / p;
      if (data_in_ack) begin
        ack_cnt++;
        ack_n.push_back(n);
      end
      if (underrun) und_cnt++;
      if (busy) busy_cnt++;
      if (n % p == 0 && k >= 2 && k <= 33) begin
        sd_vec[31 - (k - 2)] = i2s_sd;
        ws_vec[31 - (k - 2)] = i2s_ws;
      end
      if (n == abort_n) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_sck",  {31'd0, i2s_sck},     32'd0);
        chk("rst_ws",   {31'd0, i2s_ws},      32'd1);
        chk("rst_sd",   {31'd0, i2s_sd},      32'd0);
        chk("rst_ack",  {31'd0, data_in_ack}, 32'd0);
        chk("rst_und",  {31'd0, underrun},    32'd0);
        chk("rst_busy", {31'd0, busy},        32'd0);
        tx_enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      fnext = (k < 2) ? 0 : ((k - 2) / 32) + 1;
      if (fnext < nf) begin
        data_in       = tw[fnext];
        data_in_valid = tv[fnext];
      end else begin
        data_in       = 32'hDEADBEEF;
        data_in_valid = 1'b1;
      end
      tx_enable = (k < 2 + 32 * (nf - 1) + drop_bit);
      if (new_div >= 0) clk_div = DW'(new_div);
    end
  endtask

  initial begin
    rst           = 1'b1;
    tx_enable     = 1'b0;
    clk_div       = '0;
    data_in       = '0;
    data_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tw[i] = '0;
      tv[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("reset_sck",  {31'd0, i2s_sck},     32'd0);
    chk("reset_ws",   {31'd0, i2s_ws},      32'd1);
    chk("reset_sd",   {31'd0, i2s_sd},      32'd0);
    chk("reset_ack",  {31'd0, data_in_ack}, 32'd0);
    chk("reset_und",  {31'd0, underrun},    32'd0);
    chk("reset_busy", {31'd0, busy},        32'd0);
    rst = 1'b0;

    // Single frame at clk_div=1 (SCK period 4).
    tw[0] = 32'hA5A53C3C; tv[0] = 1'b1;
    run_test(1, 1, 5, -1, -1);
    chk("t1_sd_stream", sd_vec, 32'hA5A53C3C);
    chk("t1_ws_stream", ws_vec, 32'h0001FFFE);
    chk("t1_ack_cnt", ack_cnt, 32'd1);
    chk("t1_ack_time", ack_n[0], 32'd8);

    // Four back-to-back words at clk_div=0.
    tw[0] = 32'h12345678; tv[0] = 1'b1;
    tw[1] = 32'h9ABCDEF0; tv[1] = 1'b1;
    tw[2] = 32'h0F0F0F0F; tv[2] = 1'b1;
    tw[3] = 32'h80000001; tv[3] = 1'b1;
    run_test(0, 4, 5, -1, -1);
    chk("t2_ack_cnt", ack_cnt, 32'd4);
    chk("t2_ack_gap01", ack_n[1] - ack_n[0], 32'd64);
    chk("t2_ack_gap23", ack_n[3] - ack_n[2], 32'd64);

    // FIFO empty at the second frame start.
    tw[0] = 32'hC0FFEE00; tv[0] = 1'b1;
    tw[1] = 32'hFFFFFFFF; tv[1] = 1'b0;
    tw[2] = 32'h13579BDF; tv[2] = 1'b1;
    run_test(1, 3, 5, -1, -1);
    chk("t3_und_cnt", und_cnt, 32'd1);
    chk("t3_ack_cnt", ack_cnt, 32'd2);

    // Reset in the middle of the right channel (frame 0 bit 20), then restart.
    tw[0] = 32'h76543210; tv[0] = 1'b1;
    tw[1] = 32'h01234567; tv[1] = 1'b1;
    run_test(1, 2, 5, 22 * 4 + 1, -1);
    tw[0] = 32'h5A5AF00F; tv[0] = 1'b1;
    run_test(2, 1, 5, -1, -1);
    chk("t5_sd_stream", sd_vec, 32'h5A5AF00F);

    // clk_div changed 3 -> 0 while busy; next enable picks up 0.
    tw[0] = 32'h00FF00FF; tv[0] = 1'b1;
    run_test(3, 1, 5, -1, 0);
    chk("t6_busy_cycles", busy_cnt, 32'd272);
    run_test(0, 1, 5, -1, -1);
    chk("t6b_busy_cycles", busy_cnt, 32'd68);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
